// File: rtl/mult_arb_pkg.sv
// Shared types and sizing helpers for the multiplier arbiter slice.
package mult_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int unsigned NREQ_DEF    = 4;
  localparam int unsigned WIDTH_DEF   = 24;
  localparam int unsigned TIMEOUT_DEF = 32;

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // cnt reaches TIMEOUT on the exit increment, so it needs room for that value
  function automatic int unsigned cnt_width(input int unsigned t);
    return $clog2(t + 1);
  endfunction

  localparam int unsigned ID_W  = id_width(NREQ_DEF);
  localparam int unsigned CNT_W = cnt_width(TIMEOUT_DEF);

endpackage

// File: rtl/mult_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set req at or after ptr.
module rr_pick
  import mult_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned ID_W = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic            any,
  output logic [ID_W-1:0] idx
);

  // Scan farthest-first so the nearest requester after ptr is written last.
  always_comb begin
    int unsigned j;
    j   = 0;
    any = 1'b0;
    idx = '0;
    for (int unsigned k = NREQ; k > 0; k--) begin
      j = (32'(ptr) + k - 1) % NREQ;
      if (req[ID_W'(j)]) begin
        any = 1'b1;
        idx = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin front end sharing one sequential multiplier among NREQ requesters.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int unsigned NREQ    = NREQ_DEF,
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     a_in,
  input  logic [NREQ*WIDTH-1:0]     b_in,
  output logic [NREQ-1:0]           gnt,
  output logic                      mul_start,
  output logic                      mul_abort,
  output logic [WIDTH-1:0]          mul_a,
  output logic [WIDTH-1:0]          mul_b,
  input  logic                      mul_done,
  input  logic [2*WIDTH-1:0]        mul_p,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [id_width(NREQ)-1:0] rsp_id,
  output logic [2*WIDTH-1:0]        rsp_p,
  output logic                      rsp_err
);

  localparam int unsigned IW = id_width(NREQ);
  localparam int unsigned CW = cnt_width(TIMEOUT);

  state_t          state;
  logic [IW-1:0]   id_q;
  logic [IW-1:0]   rr_ptr;
  logic [CW-1:0]   cnt;
  logic            pick_any;
  logic [IW-1:0]   pick_idx;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic            timeout_hit;

  rr_pick #(
    .NREQ (NREQ),
    .ID_W (IW)
  ) u_pick (
    .req (req),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) begin
        a_sel = a_in[i*WIDTH +: WIDTH];
        b_sel = b_in[i*WIDTH +: WIDTH];
      end
    end
  end

  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      id_q      <= '0;
      rr_ptr    <= '0;
      cnt       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_abort <= 1'b0;
      rsp_p     <= '0;
      rsp_err   <= 1'b0;
    end else begin
      mul_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            id_q   <= pick_idx;
            mul_a  <= a_sel;
            mul_b  <= b_sel;
            rr_ptr <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          // done takes priority over a coincident timeout
          if (mul_done) begin
            rsp_p   <= mul_p;
            rsp_err <= 1'b0;
            state   <= RESP;
          end else if (timeout_hit) begin
            rsp_p     <= '0;
            rsp_err   <= 1'b1;
            mul_abort <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mul_start = (state == ISSUE);
  assign rsp_valid = (state == RESP);
  assign rsp_id    = id_q;

  always_comb begin
    gnt = '0;
    if (state == ISSUE) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        gnt[i] = (id_q == IW'(i));
      end
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed and randomized bench for mult_arbiter with a transaction-level reference model.
module tb_mult_arbiter;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 24;
  localparam int TIMEOUT = 32;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_in, b_in;
  logic [NREQ-1:0]       gnt;
  logic                  mul_start, mul_abort;
  logic [WIDTH-1:0]      mul_a, mul_b;
  logic                  mul_done;
  logic [2*WIDTH-1:0]    mul_p;
  logic                  rsp_valid, rsp_ready;
  logic [1:0]            rsp_id;
  logic [2*WIDTH-1:0]    rsp_p;
  logic                  rsp_err;

  always #5 clk = ~clk;

  mult_arbiter #(
    .NREQ    (NREQ),
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .mul_start (mul_start),
    .mul_abort (mul_abort),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_done  (mul_done),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .rsp_err   (rsp_err)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ref_ptr  = 0;
  int mdl_lat  = 0;
  int mdl_at   = 0;
  bit mdl_busy = 0;
  logic [WIDTH-1:0] op_a [NREQ];
  logic [WIDTH-1:0] op_b [NREQ];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; also plays the multiplier, which answers lat cycles after mul_start.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    mul_done = 1'b0;
    if (mdl_busy && cyc == mdl_at) begin
      mul_done = 1'b1;
      mul_p    = 48'(mul_a) * 48'(mul_b);
      mdl_busy = 1'b0;
    end
    if (mul_start === 1'b1) begin
      mdl_busy = (mdl_lat >= 0);
      mdl_at   = cyc + mdl_lat;
    end
  endtask

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    op_a[i] = a;
    op_b[i] = b;
    for (int k = 0; k < NREQ; k++) begin
      a_in[k*WIDTH +: WIDTH] = op_a[k];
      b_in[k*WIDTH +: WIDTH] = op_b[k];
    end
    req[i] = 1'b1;
  endtask

  function automatic int model_pick();
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (ref_ptr + k) % NREQ;
      if (req[j]) return j;
    end
    return 0;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_gnt"}, 64'(gnt), 0);
    check({tag, "_start"}, 64'(mul_start), 0);
    check({tag, "_abort"}, 64'(mul_abort), 0);
    check({tag, "_mul_a"}, 64'(mul_a), 0);
    check({tag, "_mul_b"}, 64'(mul_b), 0);
    check({tag, "_valid"}, 64'(rsp_valid), 0);
    check({tag, "_id"}, 64'(rsp_id), 0);
    check({tag, "_p"}, 64'(rsp_p), 0);
    check({tag, "_err"}, 64'(rsp_err), 0);
  endtask

  // mode: 0 drop winner's req at grant, 1 keep all, 2 drop all. lat<0: never done.
  task automatic serve(input int lat, input int mode, input int bp);
    int id, n, aborts, t0;
    logic [47:0] ep;
    bit ee;
    id      = model_pick();
    mdl_lat = lat;
    ee      = (lat < 0) || (lat > TIMEOUT);
    ep      = ee ? 48'd0 : 48'(op_a[id]) * 48'(op_b[id]);
    rsp_ready = (bp == 0);
    n = 0;
    do begin tick(); n++; end while (gnt === '0 && n < 20);
    check("gnt_latency", 64'(n), 1);
    check("gnt", 64'(gnt), 64'(1) << id);
    check("mul_start", 64'(mul_start), 1);
    t0      = cyc;
    ref_ptr = (id + 1) % NREQ;
    if (mode == 0) req[id] = 1'b0;
    else if (mode == 2) req = '0;
    aborts = 0;
    n = 0;
    do begin
      tick(); n++;
      if (mul_abort === 1'b1 && rsp_valid !== 1'b1) aborts++;
    end while (rsp_valid !== 1'b1 && n < TIMEOUT + 10);
    check("rsp_latency", 64'(cyc - t0), ee ? 64'(TIMEOUT + 1) : 64'(lat + 1));
    check("early_abort", 64'(aborts), 0);
    check("abort", 64'(mul_abort), 64'(ee));
    check("rsp_id", 64'(rsp_id), 64'(id));
    check("rsp_p", 64'(rsp_p), 64'(ep));
    check("rsp_err", 64'(rsp_err), 64'(ee));
    repeat (bp) begin
      rsp_ready = 1'b0;
      mul_done  = 1'b1;
      mul_p     = 48'({$urandom, $urandom});
      tick();
      check("bp_valid", 64'(rsp_valid), 1);
      check("bp_p", 64'(rsp_p), 64'(ep));
      check("bp_gnt", 64'(gnt), 0);
      check("bp_abort", 64'(mul_abort), 0);
    end
    rsp_ready = 1'b1;
    tick();
    check("rsp_drop", 64'(rsp_valid), 0);
    check("abort_pulse", 64'(mul_abort), 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; req = '0; a_in = '0; b_in = '0;
    mul_done = 1'b0; mul_p = '0; rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin op_a[i] = '0; op_b[i] = '0; end
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // single op, then full-scale operands
    set_req(2, 24'd3, 24'd5);
    serve(24, 0, 0);
    set_req(3, 24'hFFFFFF, 24'hFFFFFF);
    serve(24, 0, 0);

    // all requesters held: order 0,1,2,3,0
    for (int i = 0; i < NREQ; i++) set_req(i, WIDTH'(i * 7), WIDTH'(i + 1));
    for (int k = 0; k < NREQ; k++) serve(3 + k, 1, 0);
    serve(4, 2, 0);

    // timeout then normal recovery
    set_req(1, 24'd11, 24'd13);
    serve(-1, 0, 0);
    set_req(1, 24'd100, 24'd200);
    serve(7, 0, 0);

    // backpressure with a second requester pending
    set_req(2, 24'd1234, 24'd5678);
    set_req(1, 24'd9, 24'd9);
    serve(10, 0, 10);
    serve(6, 0, 0);

    // done coinciding with the timeout cycle, and done one cycle too late
    set_req(0, 24'd77, 24'd88);
    serve(TIMEOUT, 0, 0);
    set_req(0, 24'd5, 24'd6);
    serve(TIMEOUT + 1, 0, 2);

    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && ($urandom_range(0, 1) == 1))
          set_req(i, WIDTH'($urandom), WIDTH'($urandom));
      if (req == '0) set_req($urandom_range(0, NREQ - 1), WIDTH'($urandom), WIDTH'($urandom));
      serve($urandom_range(1, TIMEOUT + 2), 0, $urandom_range(0, 3));
    end
    for (int k = 0; k < NREQ && req != '0; k++) serve(5, 0, 0);

    // reset in the middle of WAIT
    set_req(1, 24'd21, 24'd22);
    mdl_lat = -1;
    n = 0;
    do begin tick(); n++; end while (gnt === '0 && n < 20);
    check("mid_gnt", 64'(gnt), 64'b0010);
    req[1] = 1'b0;
    repeat (10) tick();
    #3 rst = 1'b1;
    #1 check_zero("mid_rst");
    mdl_busy = 1'b0;
    ref_ptr  = 0;
    tick();
    tick();
    rst = 1'b0;
    repeat (3) begin
      tick();
      check("post_rst_valid", 64'(rsp_valid), 0);
      check("post_rst_gnt", 64'(gnt), 0);
    end
    set_req(3, 24'd40, 24'd50);
    serve(24, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
